spi_mem_master_burst: RTL and testbench
=======================================

Name: spi_mem_master_burst

Overview:
- Parametrised next-generation SPI memory master for the SPI memory subsystem.
- Sits between a request source (test sequence or host logic) and the SPI memory slave.
- Adds to the single-word master: configurable data/address width and memory depth, multi-word bursts with address auto-increment, and a valid/ready write-data handshake.
- Adds per-read-word output strobes, a timeout on the slave handshakes, and an error code.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address field width in bits.
- MEM_DEPTH, 32, number of words in the slave memory; legal addresses are 0..MEM_DEPTH-1.
- LEN_W, 4, width of the burst length field.
- TIMEOUT, 64, maximum cycles to wait for ready or op_done; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = write burst, 0 = read burst; latched on start.
- addr  in  ADDR_W  first word address; latched on start.
- len  in  LEN_W  number of words in the burst; latched on start.
- din  in  DATA_W  write data for the current word.
- din_valid  in  1  din is valid.
- din_ready  out  1  master accepts din; a transfer occurs when din_valid and din_ready are both 1.
- dout  out  DATA_W  last read word.
- dout_valid  out  1  one-cycle pulse, dout updated.
- mosi  out  1  serial data to the slave.
- cs  out  1  chip select, active-low.
- ready  in  1  slave has read data available.
- op_done  in  1  slave has completed the write.
- miso  in  1  serial data from the slave.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at the end of a burst, or on error.
- error  out  1  one-cycle pulse, coincident with done.
- err_code  out  2  0 = none, 1 = range/length error, 2 = timeout; sticky until the next accepted start.

Behaviour:
- Reset (asynchronous, also mid-burst):
  - State goes to IDLE immediately.
  - cs=1; mosi=0; din_ready=0; dout=0; dout_valid=0; busy=0; done=0; error=0; err_code=0.
  - Word counter, bit counter and timer clear.
- States: IDLE, CHECK, LOAD, SEND, WAIT_READY, READ, WAIT_DONE, NEXT, ERROR.
- IDLE:
  - If start=1: latch wr, addr, len; clear err_code; busy<=1; go to CHECK.
  - start is ignored in every other state.
- CHECK:
  - len==0 -> ERROR, code 1.
  - addr+len > MEM_DEPTH -> ERROR, code 1. The sum is computed at max(ADDR_W,LEN_W)+1 bits so it never wraps.
  - Otherwise cur_addr=addr, word=0, go to LOAD.
  - No cs activity on an error path.
- LOAD, write:
  - din_ready=1 while in LOAD; wait for din_valid.
  - On transfer: frame={din,cur_addr,1'b1} (F=1+ADDR_W+DATA_W bits); cs<=0; go to SEND.
- LOAD, read:
  - din_ready stays 0.
  - Next cycle: frame={cur_addr,1'b0} (F=1+ADDR_W bits); cs<=0; go to SEND.
- SEND:
  - mosi carries frame[i] in the i-th SEND cycle, LSB (the wr bit) first, for exactly F cycles.
  - Then cs<=1, mosi<=0, timer cleared.
  - Write -> WAIT_DONE; read -> WAIT_READY.
- WAIT_READY:
  - ready=1 -> READ.
  - If TIMEOUT>0 and the timer reaches TIMEOUT cycles -> ERROR, code 2.
- READ:
  - Sample miso for DATA_W cycles, LSB first.
  - The cycle after the last sample: dout<=word and dout_valid=1 for one cycle.
  - Go to NEXT.
- WAIT_DONE:
  - op_done=1 -> NEXT.
  - Timeout handled as in WAIT_READY, code 2.
- NEXT:
  - If word==len-1: done=1 for one cycle, busy<=0, go to IDLE.
  - Else: cur_addr+=1, word+=1, go to LOAD.
  - cs stays high for at least two cycles (NEXT and LOAD) between frames.
- ERROR:
  - error=1 and done=1 for one cycle.
  - cs=1, mosi=0, busy<=0, go to IDLE.
  - dout keeps its last value.
  - Words already completed in the burst are not rolled back.
- Simultaneous events:
  - ready or op_done in the same cycle the timer reaches TIMEOUT: the handshake wins.
  - start in the same cycle as done: start is ignored; the first start is accepted from the cycle after.
- Handshake inputs outside their wait states (ready, op_done) and miso outside READ are ignored.

Test Plan:
- Single write: start, wr=1, addr=5, len=1, din=0xA5 with din_valid -> cs low for exactly 17 cycles; mosi=1,1,0,1,0,0,0,0,0,1,0,1,0,0,1,0,1; after op_done, one done pulse; error=0, err_code=0.
- Read burst: wr=0, addr=3, len=3, slave returns 0x11,0x22,0x33 -> three cs-low frames of 9 cycles with addresses 3,4,5; three dout_valid pulses with those values; one done pulse after the third.
- Range error: addr=30, len=3 -> error and done pulse within 2 cycles of start; err_code=1; cs never low.
- len=0: -> err_code=1, no SPI frame.
- Timeout: read addr=0, len=1, ready held 0 -> error/done exactly 64 cycles after entering WAIT_READY; err_code=2. Repeat with ready rising on cycle 64 -> READ proceeds, no error.
- Backpressure and reset: write burst len=2, din_valid low for 10 cycles before word 1 -> cs stays high, din_ready held, no frame until the transfer. Assert rst mid-SEND -> cs=1 and busy=0 immediately; a following start runs normally.

Source files
------------

// File: rtl/spi_mem_master_burst.sv
// SPI memory master with multi-word bursts, address auto-increment,
// a valid/ready write-data port, read strobes and handshake timeout.
module spi_mem_master_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 32,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              mosi,
  output logic              cs,
  input  logic              ready,
  input  logic              op_done,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int BW = $clog2(FW + 1);
  localparam int SW = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] DEPTH = SW'(MEM_DEPTH);
  localparam logic [BW-1:0] WLAST = BW'(FW - 1);
  localparam logic [BW-1:0] RLAST = BW'(ADDR_W);
  localparam logic [BW-1:0] DLAST = BW'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_SEND,
    S_WAIT_READY,
    S_READ,
    S_WAIT_DONE,
    S_NEXT,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    word_q, word_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dv_q, dv_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic [1:0]          ec_q, ec_d;

  logic [SW-1:0]       end_addr;
  logic [BW-1:0]       flast;
  logic                last_word;

  // Range check is done one bit wider than either operand so it never wraps.
  assign end_addr  = SW'(addr_q) + SW'(len_q);
  assign flast     = wr_q ? WLAST : RLAST;
  assign last_word = (word_q == len_q - LEN_W'(1));

  assign din_ready  = (state_q == S_LOAD) && wr_q;
  assign mosi       = (state_q == S_SEND) && frame_q[0];
  assign cs         = cs_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign busy       = busy_q;
  assign error      = (state_q == S_ERROR);
  assign done       = error || ((state_q == S_NEXT) && last_word);
  assign err_code   = ec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      frame_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      ec_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      frame_q <= frame_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      ec_q    <= ec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    word_d  = word_q;
    bit_d   = bit_q;
    timer_d = timer_q;
    frame_d = frame_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    cs_d    = cs_q;
    busy_d  = busy_q;
    ec_d    = ec_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_d    = wr;
          addr_d  = addr;
          len_d   = len;
          ec_d    = 2'd0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == '0 || end_addr > DEPTH) begin
          ec_d    = 2'd1;
          state_d = S_ERROR;
        end else begin
          word_d  = '0;
          bit_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!wr_q) begin
          frame_d = {{DATA_W{1'b0}}, addr_q, 1'b0};
          cs_d    = 1'b0;
          bit_d   = '0;
          state_d = S_SEND;
        end else if (din_valid) begin
          frame_d = {din, addr_q, 1'b1};
          cs_d    = 1'b0;
          bit_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        frame_d = frame_q >> 1;
        if (bit_q == flast) begin
          cs_d    = 1'b1;
          bit_d   = '0;
          timer_d = '0;
          state_d = wr_q ? S_WAIT_DONE : S_WAIT_READY;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_WAIT_READY: begin
        // A handshake arriving on the final timer cycle still wins.
        if (ready) begin
          state_d = S_READ;
        end else if (TIMEOUT > 0 && timer_q == TLIM) begin
          ec_d    = 2'd2;
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_READ: begin
        rdata_d = {miso, rdata_q[DATA_W-1:1]};
        if (bit_q == DLAST) begin
          dout_d  = rdata_d;
          dv_d    = 1'b1;
          bit_d   = '0;
          state_d = S_NEXT;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (op_done) begin
          state_d = S_NEXT;
        end else if (TIMEOUT > 0 && timer_q == TLIM) begin
          ec_d    = 2'd2;
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_NEXT: begin
        if (last_word) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          word_d  = word_q + LEN_W'(1);
          state_d = S_LOAD;
        end
      end
      S_ERROR: begin
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_mem_master_burst.sv
// Scoreboard bench for spi_mem_master_burst: stimulus pushes expected
// frames, read words and done events; a negedge monitor checks them.
module tb_spi_mem_master_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = '0;
  logic [3:0] len = '0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       mosi;
  logic       cs;
  logic       ready = 1'b0;
  logic       op_done = 1'b0;
  logic       miso = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  spi_mem_master_burst dut (
    .clk(clk), .rst(rst), .start(start), .wr(wr),
    .addr(addr), .len(len), .din(din),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid),
    .mosi(mosi), .cs(cs), .ready(ready),
    .op_done(op_done), .miso(miso), .busy(busy),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] bits;
    int          n;
  } frame_t;

  typedef struct {
    logic       e;
    logic [1:0] code;
    int         cyc;
  } done_t;

  frame_t     exp_fr[$];
  logic [7:0] exp_do[$];
  done_t      exp_dn[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push_wr(logic [7:0] a, logic [7:0] d);
    frame_t f;
    f.bits = 32'({d, a, 1'b1});
    f.n    = 17;
    exp_fr.push_back(f);
  endtask

  task automatic push_rd(logic [7:0] a);
    frame_t f;
    f.bits = 32'({a, 1'b0});
    f.n    = 9;
    exp_fr.push_back(f);
  endtask

  task automatic push_dn(logic e, logic [1:0] code, int c);
    done_t d;
    d.e    = e;
    d.code = code;
    d.cyc  = c;
    exp_dn.push_back(d);
  endtask

  // Monitor: frames while cs is low, read strobes, done/error pulses.
  logic [31:0] cap = '0;
  int          capn = 0;
  frame_t      mf;
  done_t       md;
  logic [7:0]  mdo;

  always @(negedge clk) begin
    if (rst) begin
      capn = 0;
      cap  = '0;
    end else begin
      if (!cs) begin
        if (capn < 32) cap[capn] = mosi;
        capn++;
      end else if (capn > 0) begin
        checks++;
        if (exp_fr.size() == 0) begin
          errors++;
          $display("FAIL frame: unexpected %0d bits %h", capn, cap);
        end else begin
          mf = exp_fr.pop_front();
          if (capn != mf.n || cap != mf.bits) begin
            errors++;
            $display("FAIL frame: got %0d bits %h expected %0d bits %h",
                     capn, cap, mf.n, mf.bits);
          end
        end
        capn = 0;
        cap  = '0;
      end
      if (dout_valid) begin
        checks++;
        if (exp_do.size() == 0) begin
          errors++;
          $display("FAIL dout: unexpected strobe with %h", dout);
        end else begin
          mdo = exp_do.pop_front();
          if (dout !== mdo) begin
            errors++;
            $display("FAIL dout: got %h expected %h", dout, mdo);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_dn.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected pulse err=%b code=%0d",
                   error, err_code);
        end else begin
          md = exp_dn.pop_front();
          if (error !== md.e || err_code !== md.code ||
              (md.cyc >= 0 && cyc != md.cyc)) begin
            errors++;
            $display("FAIL done: got err=%b code=%0d cyc=%0d expected err=%b code=%0d cyc=%0d",
                     error, err_code, cyc, md.e, md.code, md.cyc);
          end
        end
      end
      if (error && !done) begin
        checks++;
        errors++;
        $display("FAIL error_done: error=%b done=%b", error, done);
      end
    end
  end

  task automatic start_burst(logic w, logic [7:0] a,
                             logic [3:0] l, output int c);
    @(negedge clk);
    wr    = w;
    addr  = a;
    len   = l;
    start = 1'b1;
    c     = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cs_rise();
    bit seen = 0;
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cs) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    chk("cs_rise_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_wait", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic write_word(logic [7:0] d);
    bit ok = 0;
    din       = d;
    din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1;
        break;
      end
    end
    chk("din_ready_wait", 32'(ok), 32'd1);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic write_word_hold(logic [7:0] d, int hold);
    bit ok = 0;
    din_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1;
        break;
      end
    end
    chk("din_ready_hold_wait", 32'(ok), 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_din_ready", 32'(din_ready), 32'd1);
      chk("hold_cs", 32'(cs), 32'd1);
    end
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic slave_read(logic [7:0] d, int k);
    wait_cs_rise();
    repeat (k) @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      miso = d[i];
      @(posedge clk);
      #1;
    end
    miso = 1'b0;
  endtask

  task automatic slave_write(int k);
    wait_cs_rise();
    repeat (k) @(negedge clk);
    op_done = 1'b1;
    @(posedge clk);
    #1 op_done = 1'b0;
  endtask

  initial begin
    int c;
    frame_t f;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    rst = 1'b0;

    // Single write, hand-computed mosi order 1,1,0,1,0,0,0,0,0,1,0,1,0,0,1,0,1
    f.bits = 32'h0001_4A0B;
    f.n    = 17;
    exp_fr.push_back(f);
    push_dn(1'b0, 2'd0, -1);
    start_burst(1'b1, 8'd5, 4'd1, c);
    write_word(8'hA5);
    slave_write(2);
    wait_idle();
    chk("wr_err_code", 32'(err_code), 32'd0);

    // Read burst of three words
    push_rd(8'd3);
    push_rd(8'd4);
    push_rd(8'd5);
    exp_do.push_back(8'h11);
    exp_do.push_back(8'h22);
    exp_do.push_back(8'h33);
    push_dn(1'b0, 2'd0, -1);
    start_burst(1'b0, 8'd3, 4'd3, c);
    slave_read(8'h11, 2);
    slave_read(8'h22, 2);
    slave_read(8'h33, 2);
    wait_idle();
    chk("rd_dout_hold", 32'(dout), 32'h33);

    // Range error: 30 + 3 > 32
    start_burst(1'b0, 8'd30, 4'd3, c);
    push_dn(1'b1, 2'd1, c + 2);
    wait_idle();
    chk("range_sticky", 32'(err_code), 32'd1);
    chk("range_dout_kept", 32'(dout), 32'h33);

    // Zero length
    start_burst(1'b1, 8'd7, 4'd0, c);
    push_dn(1'b1, 2'd1, c + 2);
    wait_idle();
    chk("len0_sticky", 32'(err_code), 32'd1);

    // Timeout: WAIT_READY entered at c+12, error 64 cycles later
    push_rd(8'd0);
    start_burst(1'b0, 8'd0, 4'd1, c);
    push_dn(1'b1, 2'd2, c + 76);
    wait_idle();
    chk("timeout_sticky", 32'(err_code), 32'd2);

    // Ready on the 64th wait cycle wins over the timeout
    push_rd(8'd0);
    exp_do.push_back(8'h5A);
    push_dn(1'b0, 2'd0, -1);
    start_burst(1'b0, 8'd0, 4'd1, c);
    chk("start_clears_code", 32'(err_code), 32'd0);
    slave_read(8'h5A, 63);
    wait_idle();

    // Write burst with backpressure before word 1
    push_wr(8'd10, 8'h3C);
    push_wr(8'd11, 8'hC3);
    push_dn(1'b0, 2'd0, -1);
    start_burst(1'b1, 8'd10, 4'd2, c);
    write_word(8'h3C);
    slave_write(2);
    write_word_hold(8'hC3, 10);
    slave_write(2);
    wait_idle();

    // Last legal address
    push_rd(8'd31);
    exp_do.push_back(8'h80);
    push_dn(1'b0, 2'd0, -1);
    start_burst(1'b0, 8'd31, 4'd1, c);
    slave_read(8'h80, 2);
    wait_idle();

    // Reset in the middle of SEND
    start_burst(1'b1, 8'd2, 4'd1, c);
    write_word(8'h77);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(cs), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mosi", 32'(mosi), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    push_wr(8'd6, 8'h96);
    push_dn(1'b0, 2'd0, -1);
    start_burst(1'b1, 8'd6, 4'd1, c);
    write_word(8'h96);
    slave_write(3);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("frames_left", 32'(exp_fr.size()), 32'd0);
    chk("reads_left", 32'(exp_do.size()), 32'd0);
    chk("dones_left", 32'(exp_dn.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
